// File: rtl/power_acc_ctrl.sv
// power_acc_ctrl: complex FFT channel -> power (re^2 + im^2) with integration control.
// Tracks channel/spectrum position from the FFT sync and issues new_acc one cycle
// ahead of the first power sample of every integration of acc_len spectra.
// Optional build macro: POWER_ACC_RESYNC_EN (a misaligned sync restarts the integration).
module power_acc_ctrl #(
  parameter int DIN_WIDTH     = 18,
  parameter int VECTOR_LEN    = 64,
  parameter int ACC_LEN_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        arm,
  input  logic [ACC_LEN_WIDTH-1:0]    acc_len,
  input  logic                        sync_in,
  input  logic signed [DIN_WIDTH-1:0] din_re,
  input  logic signed [DIN_WIDTH-1:0] din_im,
  input  logic                        din_valid,
  output logic [2*DIN_WIDTH-1:0]      pow_out,
  output logic                        pow_valid,
  output logic                        new_acc,
  output logic [31:0]                 int_count,
  output logic                        sync_err
);

  localparam int DOUT_WIDTH = 2 * DIN_WIDTH;
  localparam int CW         = (VECTOR_LEN > 1) ? $clog2(VECTOR_LEN) : 1;
  localparam logic [CW-1:0]            CHAN_LAST = CW'(VECTOR_LEN - 1);
  localparam logic [CW-1:0]            CHAN_ONE  = CW'(1);
  localparam logic [ACC_LEN_WIDTH-1:0] LEN_ONE   = ACC_LEN_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_SYNC = 2'd1,
    RUN       = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic [CW-1:0]             chan_q, chan_d;
  logic [ACC_LEN_WIDTH-1:0]  spec_q, spec_d;
  logic [ACC_LEN_WIDTH-1:0]  len_q, len_d;
  logic                      err_q, err_d;
  logic                      first_q;
  logic [31:0]               int_count_q;

  logic                      start, start_cnt, resync, step;
  logic [ACC_LEN_WIDTH-1:0]  len_eff, limit, base_spec;
  logic [CW-1:0]             base_chan;

  logic signed [DIN_WIDTH-1:0]  s1_re_q, s1_im_q;
  logic                         s1_vld_q, s1_tag_q, s1_cnt_q;
  logic signed [DOUT_WIDTH-1:0] re_sq, im_sq;
  logic [DOUT_WIDTH-1:0]        s2_re2_q, s2_im2_q;
  logic                         s2_vld_q;
  logic [DOUT_WIDTH-1:0]        pow_q;
  logic                         pow_vld_q;
  logic                         new_acc_q, new_acc_d;

  // Next-state for the FSM and the channel/spectrum position counters.
  always_comb begin
    state_d   = state_q;
    chan_d    = chan_q;
    spec_d    = spec_q;
    len_d     = len_q;
    err_d     = err_q;
    start     = 1'b0;
    start_cnt = 1'b1;
    resync    = 1'b0;
    step      = 1'b0;
    len_eff   = (acc_len == '0) ? LEN_ONE : acc_len;
    base_chan = chan_q;
    base_spec = spec_q;
    limit     = len_q;

    unique case (state_q)
      IDLE: begin
        if (arm) state_d = WAIT_SYNC;
      end
      WAIT_SYNC: begin
        if (din_valid && sync_in) begin
          state_d = RUN;
          start   = 1'b1;
          step    = 1'b1;
        end
      end
      RUN: begin
        if (din_valid) begin
          step = 1'b1;
          if (sync_in && (chan_q != '0)) begin
            err_d = 1'b1;
`ifdef POWER_ACC_RESYNC_EN
            resync = 1'b1;
`endif
          end
          // A restart aborts the partial integration, so its new_acc is not counted.
          if (resync) begin
            start     = 1'b1;
            start_cnt = 1'b0;
          end else if ((chan_q == '0) && (spec_q == '0)) begin
            start = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // The start sample is channel 0 / spectrum 0 and latches the integration length.
    if (start) begin
      base_chan = '0;
      base_spec = '0;
      limit     = len_eff;
      len_d     = len_eff;
    end

    // Counters hold the position of the next valid sample.
    if (step) begin
      if (base_chan == CHAN_LAST) begin
        chan_d = '0;
        spec_d = (base_spec == (limit - LEN_ONE)) ? '0 : (base_spec + LEN_ONE);
      end else begin
        chan_d = base_chan + CHAN_ONE;
      end
    end

    // Disarm overrides everything, including a coincident sync.
    if (!arm) begin
      state_d = IDLE;
      chan_d  = '0;
      spec_d  = '0;
      err_d   = err_q;
      start   = 1'b0;
    end
  end

  // new_acc is issued alongside the S2 stage so it leads pow_valid by one cycle.
  always_comb begin
    new_acc_d = s1_tag_q & arm;
  end

  // Signed squares of the S1 registers; results are non-negative.
  always_comb begin
    re_sq = s1_re_q * s1_re_q;
    im_sq = s1_im_q * s1_im_q;
  end

  // Control state, counters, sticky error and integration counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      chan_q      <= '0;
      spec_q      <= '0;
      len_q       <= '0;
      err_q       <= 1'b0;
      first_q     <= 1'b1;
      int_count_q <= '0;
      new_acc_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      chan_q    <= chan_d;
      spec_q    <= spec_d;
      len_q     <= len_d;
      err_q     <= err_d;
      new_acc_q <= new_acc_d;
      if (state_q == IDLE) first_q <= 1'b1;
      else if (new_acc_d)  first_q <= 1'b0;
      if (new_acc_d && s1_cnt_q && !first_q) int_count_q <= int_count_q + 32'd1;
    end
  end

  // Free-running three-stage power pipeline: S1 inputs, S2 squares, S3 sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_re_q   <= '0;
      s1_im_q   <= '0;
      s1_vld_q  <= 1'b0;
      s1_tag_q  <= 1'b0;
      s1_cnt_q  <= 1'b0;
      s2_re2_q  <= '0;
      s2_im2_q  <= '0;
      s2_vld_q  <= 1'b0;
      pow_q     <= '0;
      pow_vld_q <= 1'b0;
    end else begin
      s1_re_q   <= din_re;
      s1_im_q   <= din_im;
      s1_vld_q  <= din_valid;
      s1_tag_q  <= start;
      s1_cnt_q  <= start_cnt;
      s2_re2_q  <= $unsigned(re_sq);
      s2_im2_q  <= $unsigned(im_sq);
      s2_vld_q  <= s1_vld_q;
      pow_q     <= s2_re2_q + s2_im2_q;
      pow_vld_q <= s2_vld_q;
    end
  end

  assign pow_out   = pow_q;
  assign pow_valid = pow_vld_q;
  assign new_acc   = new_acc_q;
  assign int_count = int_count_q;
  assign sync_err  = err_q;

endmodule
